seq_detector_param: RTL and testbench

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_detector_param.sv | 65 ++++++
 tb/tb_seq_detector_param.sv | 122 ++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a runtime-loadable pattern and selectable overlap.
// Defining SEQ_DETECTOR_PARAM_COUNT_EN adds a saturating match counter; otherwise match_cnt is tied to 0.
module seq_detector_param #(
  parameter int              PAT_W     = 4,
  parameter logic [PAT_W-1:0] PAT_RESET = 4'b1101,
  parameter int              CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic [PAT_W-1:0] pat,
  input  logic             pat_load,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);
  typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_t;
  state_t           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PAT_W-2:0] sh_q, sh_d;
  logic [PAT_W-1:0] pat_q, window;
  logic             hit;
  always_comb begin
    window  = {sh_q, in};
    hit     = en && !pat_load && state_q == ARMED && window == pat_q;
    sh_d    = sh_q;
    fill_d  = fill_q;
    if (pat_load) begin
      sh_d   = '0;
      fill_d = '0;
    end else if (en) begin
      sh_d   = window[PAT_W-2:0];
      fill_d = hit ? (overlap ? FULL : '0) : (fill_q == FULL ? FULL : fill_q + FW'(1));
    end
    state_d = fill_d == '0 ? EMPTY : fill_d == FULL ? ARMED : FILLING;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q   <= PAT_RESET;
      sh_q    <= '0;
      fill_q  <= '0;
      state_q <= EMPTY;
      out     <= 1'b0;
    end else begin
      pat_q   <= pat_load ? pat : pat_q;
      sh_q    <= sh_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      out     <= hit;
    end
  end
`ifdef SEQ_DETECTOR_PARAM_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else if (hit && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end
  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed and random checks of seq_detector_param against a bit-history model.
module tb_seq_detector_param;
`ifdef SEQ_DETECTOR_PARAM_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in = 1'b0, en = 1'b0, pat_load = 1'b0, overlap = 1'b0;
  logic [3:0] pat = 4'b0;
  logic out8, out2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  int tests = 0, fails = 0, pulses = 0;
  bit cur_ov = 1'b0;
  logic [3:0] m_pat;
  bit hist[$];
  bit m_out;
  int m_c8, m_c2;
  seq_detector_param u8 (.clk(clk), .rst(rst), .in(in), .en(en), .pat(pat), .pat_load(pat_load),
                         .overlap(overlap), .out(out8), .match_cnt(cnt8));
  seq_detector_param #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .in(in), .en(en), .pat(pat), .pat_load(pat_load),
                         .overlap(overlap), .out(out2), .match_cnt(cnt2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input bit r, input bit e, input bit b, input bit pl, input logic [3:0] p, input bit ov);
    bit hit;
    rst = r; en = e; in = b; pat_load = pl; pat = p; overlap = ov;
    @(posedge clk);
    hit = 1'b0;
    if (!r) begin
      m_pat = 4'b1101; hist.delete(); m_out = 1'b0; m_c8 = 0; m_c2 = 0;
    end else if (pl) begin
      m_pat = p; hist.delete(); m_out = 1'b0;
    end else if (e) begin
      hist.push_back(b);
      if (hist.size() > 4) void'(hist.pop_front());
      hit = hist.size() == 4 && {hist[0], hist[1], hist[2], hist[3]} == m_pat;
      m_out = hit;
      if (hit) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
        if (!ov) hist.delete();
      end
    end else m_out = 1'b0;
    #1;
    chk("out8", int'(out8), int'(m_out));
    chk("out2", int'(out2), int'(m_out));
    chk("cnt8", int'(cnt8), CNT_ON ? m_c8 : 0);
    chk("cnt2", int'(cnt2), CNT_ON ? m_c2 : 0);
    if (out8 === 1'b1) pulses++;
  endtask
  task automatic bit_in(input bit b);
    step(1'b1, 1'b1, b, 1'b0, 4'b0, cur_ov);
  endtask
  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, cur_ov);
    pulses = 0;
  endtask
  initial begin
    bit s[7] = '{1, 1, 0, 1, 1, 0, 1};
    cur_ov = 1'b1;
    do_reset();
    chk("reset_out", int'(out8), 0);
    foreach (s[i]) bit_in(s[i]);
    chk("ovl_pulses", pulses, 2);
    chk("ovl_cnt", int'(cnt8), CNT_ON ? 2 : 0);
    cur_ov = 1'b0;
    do_reset();
    foreach (s[i]) bit_in(s[i]);
    chk("novl_pulses", pulses, 1);
    chk("novl_cnt", int'(cnt8), CNT_ON ? 1 : 0);
    cur_ov = 1'b1;
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, cur_ov);
    repeat (8) bit_in(1'b1);
    chk("reload_ovl_pulses", pulses, 5);
    cur_ov = 1'b0;
    pulses = 0;
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, cur_ov);
    repeat (8) bit_in(1'b1);
    chk("reload_novl_pulses", pulses, 2);
    cur_ov = 1'b1;
    do_reset();
    bit_in(1'b1);
    bit_in(1'b1);
    repeat (3) begin
      step(1'b1, 1'b0, 1'($urandom), 1'b0, 4'b0, cur_ov);
      chk("gap_out", int'(out8), 0);
    end
    bit_in(1'b0);
    bit_in(1'b1);
    chk("gap_pulses", pulses, 1);
    chk("gap_last_out", int'(out8), 1);
    do_reset();
    bit_in(1'b1);
    bit_in(1'b1);
    bit_in(1'b0);
    do_reset();
    chk("midrst_cnt", int'(cnt8), 0);
    bit_in(1'b1);
    chk("midrst_pulses", pulses, 0);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, cur_ov);
    repeat (10) bit_in(1'b1);
    chk("sat_pulses", pulses, 7);
    chk("sat_cnt2", int'(cnt2), CNT_ON ? 3 : 0);
    chk("sat_cnt8", int'(cnt8), CNT_ON ? 7 : 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) cur_ov = ~cur_ov;
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 19) == 0, 4'($urandom), cur_ov);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
